// File: rtl/qpu_exu_alu_dpath_arb.sv
// Shared EXU ALU datapath: round-robin arbitration between the ALU (port 0) and the branch/compare unit (port 1), one-cycle latency, one-entry response buffer.
// Optional compare ops (slt/sltu) are built when QPU_ALU_DPATH_CMP_EN is defined.
module qpu_exu_alu_dpath_arb #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_add,
    input  logic            req0_sub,
    input  logic            req0_xor,
    input  logic            req0_or,
    input  logic            req0_and,
`ifdef QPU_ALU_DPATH_CMP_EN
    input  logic            req0_slt,
    input  logic            req0_sltu,
`endif
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_add,
    input  logic            req1_sub,
    input  logic            req1_xor,
    input  logic            req1_or,
    input  logic            req1_and,
`ifdef QPU_ALU_DPATH_CMP_EN
    input  logic            req1_slt,
    input  logic            req1_sltu,
`endif
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_res,
    output logic            rsp_id
);

`ifdef QPU_ALU_DPATH_CMP_EN
    localparam int unsigned NOPS = 7;
`else
    localparam int unsigned NOPS = 5;
`endif

    logic [NOPS-1:0] sel0;
    logic [NOPS-1:0] sel1;
    logic [NOPS-1:0] sel_g;
    logic [XLEN-1:0] op1_g;
    logic [XLEN-1:0] op2_g;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] result;
    logic            rr_ptr;
    logic            grant_id;
    logic            both_valid;
    logic            buf_free;
    logic            fire;

`ifdef QPU_ALU_DPATH_CMP_EN
    assign sel0 = {req0_sltu, req0_slt, req0_and, req0_or, req0_xor, req0_sub, req0_add};
    assign sel1 = {req1_sltu, req1_slt, req1_and, req1_or, req1_xor, req1_sub, req1_add};
`else
    assign sel0 = {req0_and, req0_or, req0_xor, req0_sub, req0_add};
    assign sel1 = {req1_and, req1_or, req1_xor, req1_sub, req1_add};
`endif

    // Handshake: a request fires on reqN_valid & reqN_ready; the requester holds
    // valid/ops/operands until then. Ready depends on valid, never the reverse.
    // The response leaves on rsp_valid & rsp_ready; a same-cycle pop frees the slot.
    assign buf_free   = !rsp_valid || rsp_ready;
    assign both_valid = req0_valid && req1_valid;
    assign grant_id   = both_valid ? rr_ptr : req1_valid;
    assign req0_ready = !rst && buf_free && req0_valid && !grant_id;
    assign req1_ready = !rst && buf_free && req1_valid && grant_id;
    assign fire       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign sel_g = grant_id ? sel1 : sel0;
    assign op1_g = grant_id ? req1_op1 : req0_op1;
    assign op2_g = grant_id ? req1_op2 : req0_op2;
    assign sum   = op1_g + op2_g;
    assign diff  = op1_g - op2_g;

    // AND-OR mux: an illegal multi-select yields the OR of the selected results.
    always_comb begin
        result = '0;
        result = result | ({XLEN{sel_g[0]}} & sum);
        result = result | ({XLEN{sel_g[1]}} & diff);
        result = result | ({XLEN{sel_g[2]}} & (op1_g ^ op2_g));
        result = result | ({XLEN{sel_g[3]}} & (op1_g | op2_g));
        result = result | ({XLEN{sel_g[4]}} & (op1_g & op2_g));
`ifdef QPU_ALU_DPATH_CMP_EN
        result = result | {{(XLEN-1){1'b0}}, sel_g[5] && ($signed(op1_g) < $signed(op2_g))};
        result = result | {{(XLEN-1){1'b0}}, sel_g[6] && (op1_g < op2_g)};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_id    <= 1'b0;
            rr_ptr    <= 1'b0;
        end else begin
            if (fire) begin
                rsp_valid <= 1'b1;
                rsp_res   <= result;
                rsp_id    <= grant_id;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            // Priority only moves on contention, so a lone requester keeps none.
            if (both_valid && fire) begin
                rr_ptr <= ~grant_id;
            end
        end
    end

    a_onehot_sel: assert property (@(posedge clk) disable iff (rst) fire |-> $onehot0(sel_g));

endmodule

// File: tb/tb_qpu_exu_alu_dpath_arb.sv
// Randomized self-checking bench for qpu_exu_alu_dpath_arb against a queue-based reference model.
// Define QPU_ALU_DPATH_CMP_EN to exercise the slt/sltu ops as well.
module tb_qpu_exu_alu_dpath_arb;

    localparam int XLEN = 32;
`ifdef QPU_ALU_DPATH_CMP_EN
    localparam int NSEL = 7;
`else
    localparam int NSEL = 5;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [NSEL-1:0] s0, s1;
    logic [XLEN-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic            rsp_valid, rsp_ready, rsp_id;
    logic [XLEN-1:0] rsp_res;

    // clock / reset
    always #5 clk = ~clk;

    qpu_exu_alu_dpath_arb #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_add(s0[0]), .req0_sub(s0[1]), .req0_xor(s0[2]), .req0_or(s0[3]), .req0_and(s0[4]),
`ifdef QPU_ALU_DPATH_CMP_EN
        .req0_slt(s0[5]), .req0_sltu(s0[6]),
`endif
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_add(s1[0]), .req1_sub(s1[1]), .req1_xor(s1[2]), .req1_or(s1[3]), .req1_and(s1[4]),
`ifdef QPU_ALU_DPATH_CMP_EN
        .req1_slt(s1[5]), .req1_sltu(s1[6]),
`endif
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_id(rsp_id)
    );

    // scoreboard / model state
    logic [XLEN:0]   exp_q[$];
    logic [XLEN-1:0] last_res;
    logic            last_id;
    logic            pri;
    logic            known;
    int              n_vec = 0;
    int              n_err = 0;

    // requester state: what each port presents this cycle, and whether it fired
    logic            pv[2];
    logic [NSEL-1:0] ps[2];
    logic [XLEN-1:0] pa[2];
    logic [XLEN-1:0] pb[2];
    logic            fired[2];

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NSEL-1:0] op(input int idx);
        logic [NSEL-1:0] one;
        one = 1;
        return one << idx;
    endfunction

    function automatic logic [XLEN-1:0] ref_alu(input logic [NSEL-1:0] s, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        r = '0;
        if (s[0]) r |= a + b;
        if (s[1]) r |= a - b;
        if (s[2]) r |= a ^ b;
        if (s[3]) r |= a | b;
        if (s[4]) r |= a & b;
`ifdef QPU_ALU_DPATH_CMP_EN
        if (s[5]) r |= (int'(a) < int'(b)) ? 1 : 0;
        if (s[6]) r |= (a < b) ? 1 : 0;
`endif
        return r;
    endfunction

    task automatic set_port(input int i, input logic v, input logic [NSEL-1:0] s,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        pv[i] = v; ps[i] = s; pa[i] = a; pb[i] = b;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check readies, advance the model.
    task automatic drive_cycle(input logic r, input logic rr_in);
        logic            free, g, er0, er1, id;
        logic [XLEN:0]   e;
        if (known) begin
            check("rsp_valid", XLEN'(rsp_valid), XLEN'(exp_q.size() != 0));
            e = (exp_q.size() != 0) ? exp_q[0] : {last_id, last_res};
            check("rsp_res", rsp_res, e[XLEN-1:0]);
            check("rsp_id", XLEN'(rsp_id), XLEN'(e[XLEN]));
        end
        rst = r; rsp_ready = rr_in;
        req0_valid = pv[0]; s0 = ps[0]; req0_op1 = pa[0]; req0_op2 = pb[0];
        req1_valid = pv[1]; s1 = ps[1]; req1_op1 = pa[1]; req1_op2 = pb[1];
        #1;
        free = (exp_q.size() == 0) || rr_in;
        g    = (pv[0] && pv[1]) ? pri : pv[1];
        er0  = !r && free && pv[0] && !g;
        er1  = !r && free && pv[1] && g;
        check("req0_ready", XLEN'(req0_ready), XLEN'(er0));
        check("req1_ready", XLEN'(req1_ready), XLEN'(er1));
        fired[0] = er0; fired[1] = er1;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            last_res = '0; last_id = 1'b0; pri = 1'b0;
            known = 1'b1;
        end else begin
            if (exp_q.size() != 0 && rr_in) void'(exp_q.pop_front());
            if (er0 || er1) begin
                id = er1;
                last_id  = id;
                last_res = ref_alu(ps[id], pa[id], pb[id]);
                exp_q.push_back({last_id, last_res});
                if (pv[0] && pv[1]) pri = ~id;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [XLEN-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [NSEL-1:0] rand_sel();
        if ($urandom_range(0, 9) == 0) return '0;
        return op($urandom_range(0, NSEL - 1));
    endfunction

    initial begin
        known = 1'b0; pri = 1'b0; last_res = '0; last_id = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_port(i, 1'b0, '0, '0, '0);
            fired[i] = 1'b0;
        end
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; s0 = '0; s1 = '0;
        req0_op1 = '0; req0_op2 = '0; req1_op1 = '0; req1_op2 = '0;
        @(negedge clk);

        // reset held two cycles with both ports requesting; port 0 wins after release
        set_port(0, 1'b1, op(0), 32'h1, 32'h1);
        set_port(1, 1'b1, op(0), 32'h2, 32'h2);
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b0, 1'b1);
        check("first_grant_id", XLEN'(rsp_id), 0);
        set_port(0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, '0, '0, '0);
        drive_cycle(1'b0, 1'b1);

        // lone port 0: add wraps, sub borrows
        set_port(0, 1'b1, op(0), 32'hFFFF_FFFF, 32'h2);
        drive_cycle(1'b0, 1'b1);
        check("add_wrap", rsp_res, 32'h0000_0001);
        set_port(0, 1'b1, op(1), 32'h3, 32'h5);
        drive_cycle(1'b0, 1'b1);
        check("sub_borrow", rsp_res, 32'hFFFF_FFFE);
        set_port(0, 1'b0, '0, '0, '0);
        drive_cycle(1'b1, 1'b1);

        // contention: grants alternate 0,1,0,1 with one response per cycle
        set_port(0, 1'b1, op(2), 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        set_port(1, 1'b1, op(4), 32'hAAAA_5555, 32'hFFFF_0000);
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, 1'b1);
            check("alt_id", XLEN'(rsp_id), XLEN'(k % 2));
            check("alt_res", rsp_res, (k % 2 == 0) ? 32'hFFFF_FFFF : 32'hAAAA_0000);
        end

        // backpressure for 3 cycles, then the waiting request fires as rsp_ready rises
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b0, 1'b1);
        set_port(0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, '0, '0, '0);
        drive_cycle(1'b0, 1'b1);

        // no operation selected gives zero
        set_port(0, 1'b1, '0, 32'h5, 32'h7);
        drive_cycle(1'b0, 1'b1);
        check("no_sel", rsp_res, 32'h0);
`ifdef QPU_ALU_DPATH_CMP_EN
        set_port(0, 1'b1, op(5), 32'hFFFF_FFFF, 32'h1);
        drive_cycle(1'b0, 1'b1);
        check("slt", rsp_res, 32'h1);
        set_port(0, 1'b1, op(6), 32'hFFFF_FFFF, 32'h1);
        drive_cycle(1'b0, 1'b1);
        check("sltu", rsp_res, 32'h0);
`endif

        // reset while a response is stalled: it is dropped and priority returns to port 0
        set_port(0, 1'b1, op(0), 32'h10, 32'h20);
        set_port(1, 1'b1, op(3), 32'h1, 32'h2);
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b0, 1'b1);
        set_port(0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, '0, '0, '0);
        drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0);
        check("reset_drop_valid", XLEN'(rsp_valid), 0);
        set_port(0, 1'b1, op(0), 32'h1, 32'h1);
        set_port(1, 1'b1, op(0), 32'h2, 32'h2);
        drive_cycle(1'b0, 1'b1);
        check("post_reset_grant", XLEN'(rsp_id), 0);

        // random traffic; a port keeps its request until it fires
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] || fired[i])
                    set_port(i, $urandom_range(0, 3) != 0, rand_sel(), rand_operand(), rand_operand());
            end
            drive_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
        end
        drive_cycle(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qpu_exu_alu_dpath_arb.md
Name: qpu_exu_alu_dpath_arb

Overview:
- Shared ALU datapath responder. It serves requests from two clients: port 0 (regular ALU) and port 1 (branch/compare unit).
- Each cycle it arbitrates round-robin, computes the one-hot selected operation, and registers the result into a one-entry response buffer.
- The response returns over a valid/ready interface tagged with the requester id.
- It sits in the EXU between the ALU sub-units and the writeback/commit path.

Parameters:
- XLEN, 32, operand and result width in bits.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_add, req0_sub, req0_xor, req0_or, req0_and  input  1 each  port 0 operation selects, one-hot.
- req0_op1, req0_op2  input  XLEN each  port 0 operands.
- req1_valid  input  1  port 1 request valid.
- req1_ready  output  1  port 1 request accepted this cycle.
- req1_add, req1_sub, req1_xor, req1_or, req1_and  input  1 each  port 1 operation selects.
- req1_op1, req1_op2  input  XLEN each  port 1 operands.
- rsp_valid  output  1  response buffer holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_res  output  XLEN  registered result.
- rsp_id  output  1  requester of rsp_res (0 or 1).

Behaviour:
- Reset: the reset is synchronous and active-high (rst). While rst is high at a clock edge:
  - rsp_valid=0, rsp_res=0, rsp_id=0.
  - Round-robin pointer rr_ptr=0 (port 0 has priority first).
  - reqN_ready is combinational and forced to 0 while rst=1.
  - Reset mid-operation discards any buffered response with no output handshake.
- Buffer accept condition: buf_free = !rsp_valid | rsp_ready. This is a pass-through on a same-cycle pop, so throughput is 1 request per cycle.
- Arbitration, combinational:
  - If only one reqN_valid is high, grant that port.
  - If both are high, grant port rr_ptr.
  - req_ready is asserted only for the granted port AND buf_free. The non-granted port's ready is 0.
- Handshake: a request fires when reqN_valid & reqN_ready. The requester must hold valid, ops and operands stable until it fires. Ready may depend on valid; valid must not depend on ready.
- rr_ptr update: only on a cycle where both ports are valid and a grant fires, rr_ptr <= ~granted_id. Otherwise it is unchanged, so a lone requester does not steal priority.
- Operations, on XLEN bits, modulo 2^XLEN, carry/borrow discarded:
  - add = op1+op2
  - sub = op1-op2
  - xor, or, and are bitwise.
- Result mux is an OR of (select & result) per op:
  - No select set → result 0.
  - Multiple selects is illegal. Its result is the OR of the selected results, and the SVA flags it.
- Latency: exactly 1 cycle. A request firing in cycle T produces rsp_valid=1, rsp_res and rsp_id in cycle T+1.
- Response register:
  - On fire: rsp_valid<=1, rsp_res<=result, rsp_id<=granted id.
  - On rsp_valid & rsp_ready with no fire: rsp_valid<=0; rsp_res and rsp_id hold their last values.
  - On stall (rsp_valid & !rsp_ready): all response outputs hold, and both reqN_ready are 0.
- Simultaneous pop and push in one cycle: the new result replaces the old one with no bubble.

Optional Feature:
- Macro: QPU_ALU_DPATH_CMP_EN.
- When defined:
  - Adds inputs req0_slt, req0_sltu, req1_slt, req1_sltu (1 bit each).
  - slt gives result {XLEN-1 zeros, signed(op1)<signed(op2)}; sltu gives the unsigned compare.
  - Both take part in the same OR-mux with the same latency.
- When undefined: these ports do not exist and no comparator logic is built.

Test Plan:
- Reset: hold rst=1 for 2 cycles with both reqN_valid=1 → rsp_valid=0, rsp_res=0, req0_ready=req1_ready=0. Release rst → port 0 granted first.
- Single port 0 add, op1=0xFFFF_FFFF, op2=2 → next cycle rsp_valid=1, rsp_res=0x0000_0001, rsp_id=0. Also port 0 sub, 3-5 → 0xFFFF_FFFE.
- Both ports valid continuously, rsp_ready=1:
  - Port 0 xor 0xF0F0_F0F0^0x0F0F_0F0F = 0xFFFF_FFFF; port 1 and 0xAAAA_5555&0xFFFF_0000 = 0xAAAA_0000.
  - Grants alternate 0,1,0,1, giving rsp_id sequence 0,1,0,1 with one response per cycle.
- Backpressure: rsp_ready=0 for 3 cycles after the first response → rsp_res/rsp_id stable, both ready=0. When rsp_ready rises, the pending request fires in the same cycle and the new result appears next cycle.
- No op select with op1=5, op2=7 → rsp_res=0. With QPU_ALU_DPATH_CMP_EN defined: slt(0xFFFF_FFFF, 1) → 1 and sltu(0xFFFF_FFFF, 1) → 0.
- Reset asserted while rsp_valid=1 and rsp_ready=0 → next cycle rsp_valid=0 and rr_ptr=0; the discarded result never handshakes.
